// File: rtl/soc2_uart_pkg.sv
// soc2_uart_pkg
//   Shared definitions for the soc2 UART receive path: deframer state
//   encoding, oversampling constants and the field limits derived from them.
package soc2_uart_pkg;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_START = 3'd1,
      S_DATA  = 3'd2,
      S_STOP  = 3'd3,
      S_BREAK = 3'd4
   } rx_state_e;

   localparam int unsigned OVERSAMPLE = 16;
   localparam int unsigned MID_SAMPLE = 7;
   localparam int unsigned DATA_BITS  = 8;

   localparam logic [3:0] SUB_MID  = 4'(MID_SAMPLE);
   localparam logic [3:0] SUB_LAST = 4'(OVERSAMPLE - 1);
   localparam logic [2:0] BIT_LAST = 3'(DATA_BITS - 1);

endpackage

// File: rtl/uart_rx_fifo_buf.sv
// uart_rx_fifo_buf
//   Synchronous FIFO buffering received bytes. Head entry is presented
//   combinationally on dout_o. A push into a full FIFO is accepted only
//   when a pop frees a slot in the same cycle; a pop on an empty FIFO is
//   ignored.
// Ports
//   clk      in   system clock
//   rst      in   asynchronous reset, active-high
//   push_i   in   write din_i this cycle
//   pop_i    in   consume the head entry this cycle
//   din_i    in   WIDTH  write data
//   dout_o   out  WIDTH  head entry
//   count_o  out  entries held, 0..DEPTH
//   full_o   out  count_o == DEPTH
//   empty_o  out  count_o == 0
module uart_rx_fifo_buf #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push_i,
   input  logic                     pop_i,
   input  logic [WIDTH-1:0]         din_i,
   output logic [WIDTH-1:0]         dout_o,
   output logic [$clog2(DEPTH):0]   count_o,
   output logic                     full_o,
   output logic                     empty_o
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH) + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_q;
   logic [AW-1:0]    rd_q;
   logic [CW-1:0]    cnt_q;
   logic             do_push;
   logic             do_pop;

   assign full_o  = (cnt_q == CW'(DEPTH));
   assign empty_o = (cnt_q == '0);
   assign do_pop  = pop_i & ~empty_o;
   // A full FIFO still accepts a push when the same cycle frees a slot.
   assign do_push = push_i & (~full_o | do_pop);

   assign dout_o  = mem_q[rd_q];
   assign count_o = cnt_q;

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (do_push) begin
            mem_q[wr_q] <= din_i;
            wr_q        <= wr_q + 1'b1;
         end
         if (do_pop) rd_q <= rd_q + 1'b1;
         case ({do_push, do_pop})
            2'b10:   cnt_q <= cnt_q + 1'b1;
            2'b01:   cnt_q <= cnt_q - 1'b1;
            default: cnt_q <= cnt_q;
         endcase
      end
   end

endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
//   8N1 UART receiver front end: 2-FF synchroniser on the pad, free-running
//   1/16-bit tick divider, deframer FSM with 16x oversampling, receive FIFO
//   and sticky frame-error / overrun flags.
// Ports
//   clk        in   system clock
//   reset      in   asynchronous reset, active-high
//   uart_rx    in   serial input, idle high, asynchronous to clk
//   rx_pop     in   consume the FIFO head (ignored when empty)
//   err_clr    in   clear frame_err and overrun
//   rx_data    out  8  FIFO head byte, valid while rx_valid
//   rx_valid   out  FIFO not empty
//   rx_count   out  bytes held, 0..FIFO_DEPTH
//   rx_busy    out  deframer not idle
//   frame_err  out  sticky: stop bit sampled low
//   overrun    out  sticky: byte completed while FIFO full and dropped
module uart_rx_fifo
   import soc2_uart_pkg::*;
#(
   parameter int unsigned OVERSAMPLE_DIV = 13,
   parameter int unsigned FIFO_DEPTH     = 4
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         uart_rx,
   input  logic                         rx_pop,
   input  logic                         err_clr,
   output logic [7:0]                   rx_data,
   output logic                         rx_valid,
   output logic [$clog2(FIFO_DEPTH):0]  rx_count,
   output logic                         rx_busy,
   output logic                         frame_err,
   output logic                         overrun
);

   localparam int unsigned DW = (OVERSAMPLE_DIV > 1) ? $clog2(OVERSAMPLE_DIV) : 1;

   logic                 sync1_q;
   logic                 rxs_q;
   logic [DW-1:0]        div_q;
   logic                 tick;

   rx_state_e            state_q, state_d;
   logic [3:0]           sub_q, sub_d;
   logic [2:0]           bit_q, bit_d;
   logic [DATA_BITS-1:0] shreg_q, shreg_d;

   logic                 push;
   logic                 ferr_set;
   logic                 frame_err_q, frame_err_d;
   logic                 overrun_q, overrun_d;
   logic                 fifo_full;
   logic                 fifo_empty;

   // Synchroniser and tick divider
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1_q <= 1'b1;
         rxs_q   <= 1'b1;
         div_q   <= '0;
      end else begin
         sync1_q <= uart_rx;
         rxs_q   <= sync1_q;
         div_q   <= tick ? '0 : div_q + 1'b1;
      end
   end

   assign tick = (div_q == DW'(OVERSAMPLE_DIV - 1));

   // Deframer state
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         sub_q       <= '0;
         bit_q       <= '0;
         shreg_q     <= '0;
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         sub_q       <= sub_d;
         bit_q       <= bit_d;
         shreg_q     <= shreg_d;
         frame_err_q <= frame_err_d;
         overrun_q   <= overrun_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      sub_d    = sub_q;
      bit_d    = bit_q;
      shreg_d  = shreg_q;
      push     = 1'b0;
      ferr_set = 1'b0;
      if (tick) begin
         case (state_q)
            S_IDLE: begin
               if (!rxs_q) begin
                  sub_d   = '0;
                  state_d = S_START;
               end
            end
            S_START: begin
               if (sub_q == SUB_MID) begin
                  if (!rxs_q) begin
                     state_d = S_DATA;
                     sub_d   = '0;
                     bit_d   = '0;
                  end else begin
                     state_d = S_IDLE;
                  end
               end else begin
                  sub_d = sub_q + 1'b1;
               end
            end
            S_DATA: begin
               // sub wraps 15->0, so the next bit (or STOP) restarts at 0.
               sub_d = sub_q + 1'b1;
               if (sub_q == SUB_LAST) begin
                  shreg_d = {rxs_q, shreg_q[DATA_BITS-1:1]};
                  if (bit_q == BIT_LAST) state_d = S_STOP;
                  else                   bit_d   = bit_q + 1'b1;
               end
            end
            S_STOP: begin
               if (sub_q == SUB_LAST) begin
                  if (rxs_q) begin
                     push    = 1'b1;
                     state_d = S_IDLE;
                  end else begin
                     ferr_set = 1'b1;
                     state_d  = S_BREAK;
                  end
               end else begin
                  sub_d = sub_q + 1'b1;
               end
            end
            S_BREAK: begin
               if (rxs_q) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   // A fresh error in the clearing cycle keeps its flag set.
   always_comb begin
      frame_err_d = ferr_set | (frame_err_q & ~err_clr);
      overrun_d   = (push & fifo_full & ~rx_pop) | (overrun_q & ~err_clr);
   end

   uart_rx_fifo_buf #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (DATA_BITS)
   ) u_buf (
      .clk     (clk),
      .rst     (reset),
      .push_i  (push),
      .pop_i   (rx_pop),
      .din_i   (shreg_q),
      .dout_o  (rx_data),
      .count_o (rx_count),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   assign rx_valid  = ~fifo_empty;
   assign rx_busy   = (state_q != S_IDLE);
   assign frame_err = frame_err_q;
   assign overrun   = overrun_q;

endmodule
